// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop line synchroniser, 5..8 data bits, optional
// even/odd parity, 1 or 2 stop bits, with valid/ready output holding and overrun flag.
module uart_rx_cfg #(
  parameter int unsigned CLK_HZ       = 100000000,
  parameter int unsigned BIT_RATE     = 9600,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    rx_en,
  output logic [PAYLOAD_BITS-1:0] rx_data,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic                    rx_parity_err,
  output logic                    rx_frame_err,
  output logic                    rx_break,
  output logic                    rx_overrun
);

  localparam int unsigned CPB = CLK_HZ / BIT_RATE;
  localparam int unsigned CW  = $clog2(CPB + 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CPB / 2);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
  localparam logic [3:0]    DATA_LAST = 4'(PAYLOAD_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic                    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [3:0]              bit_q, bit_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic                    perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d;
  logic                    deliver_q, deliver_d;
  logic [PAYLOAD_BITS-1:0] rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d;
  logic                    rx_brk_q, rx_brk_d, rx_ovr_q, rx_ovr_d;
  logic                    line, bit_centre, handshake;

  always_comb begin
    sync1_d    = uart_rxd;
    sync2_d    = sync1_q;
    line       = sync2_q;
    bit_centre = (cnt_q == CNT_LAST);
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    brk_d      = brk_q;
    deliver_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!line) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          if (line) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            cnt_d   = '0;
            bit_d   = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            brk_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_centre) begin
          cnt_d   = '0;
          shift_d = {line, shift_q[PAYLOAD_BITS-1:1]};
          brk_d   = brk_q & ~line;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PARITY: begin
        if (bit_centre) begin
          cnt_d   = '0;
          perr_d  = (PARITY == 2) ? ~(^shift_q ^ line) : (^shift_q ^ line);
          brk_d   = brk_q & ~line;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        // The frame is handed over one cycle after the last stop sample, while still in STOP.
        if (deliver_q) begin
          state_d = line ? ST_IDLE : ST_WAIT_HIGH;
        end else if (bit_centre) begin
          cnt_d = '0;
          if (!line) ferr_d = 1'b1;
          if (bit_q == 4'd0) brk_d = brk_q & ~line;
          if (bit_q == STOP_LAST) deliver_d = 1'b1;
          else                    bit_d     = bit_q + 4'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_HIGH: begin
        if (line) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!rx_en) begin
      state_d   = ST_IDLE;
      deliver_d = 1'b0;
    end
  end

  always_comb begin
    handshake  = rx_valid_q & rx_ready;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    rx_brk_d   = rx_brk_q;
    rx_ovr_d   = rx_ovr_q;
    if (deliver_q) begin
      if (!rx_valid_q || handshake) begin
        rx_data_d  = shift_q;
        rx_perr_d  = perr_q;
        rx_ferr_d  = ferr_q;
        rx_brk_d   = brk_q;
        rx_valid_d = 1'b1;
        if (handshake) rx_ovr_d = 1'b0;
      end else begin
        rx_ovr_d = 1'b1;
      end
    end else if (handshake) begin
      rx_valid_d = 1'b0;
      rx_ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      deliver_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_brk_q   <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
      deliver_q  <= deliver_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_brk_q   <= rx_brk_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_break      = rx_brk_q;
  assign rx_overrun    = rx_ovr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations (8N1, 7E1, 8N2) at 10 clocks per bit,
// expected frames queued when driven and compared when the receiver presents them.
module tb_uart_rx_cfg;
  localparam int unsigned CLK_HZ   = 1000000;
  localparam int unsigned BIT_RATE = 100000;
  localparam int CPB = 10;

  logic clk = 1'b0;
  logic resetn, rx_en;
  always #5 clk = ~clk;

  logic       rxd_a, valid_a, ready_a, perr_a, ferr_a, brk_a, ovr_a;
  logic [7:0] data_a;
  logic       rxd_b, valid_b, ready_b, perr_b, ferr_b, brk_b, ovr_b;
  logic [6:0] data_b;
  logic       rxd_c, valid_c, ready_c, perr_c, ferr_c, brk_c, ovr_c;
  logic [7:0] data_c;

  uart_rx_cfg #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd_a), .rx_en(rx_en), .rx_data(data_a),
    .rx_valid(valid_a), .rx_ready(ready_a), .rx_parity_err(perr_a), .rx_frame_err(ferr_a),
    .rx_break(brk_a), .rx_overrun(ovr_a));

  uart_rx_cfg #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(7), .PARITY(1), .STOP_BITS(1)) u_b (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd_b), .rx_en(rx_en), .rx_data(data_b),
    .rx_valid(valid_b), .rx_ready(ready_b), .rx_parity_err(perr_b), .rx_frame_err(ferr_b),
    .rx_break(brk_b), .rx_overrun(ovr_b));

  uart_rx_cfg #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(8), .PARITY(0), .STOP_BITS(2)) u_c (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd_c), .rx_en(rx_en), .rx_data(data_c),
    .rx_valid(valid_c), .rx_ready(ready_c), .rx_parity_err(perr_c), .rx_frame_err(ferr_c),
    .rx_break(brk_c), .rx_overrun(ovr_c));

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
    logic       valid;
    logic       ovr;
    logic [2:0] state;
  } obs_t;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT_HIGH = 3'd5;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic obs_t observe(input int which);
    obs_t o;
    case (which)
      0:       o = {data_a, perr_a, ferr_a, brk_a, valid_a, ovr_a, 3'(u_a.state_q)};
      1:       o = {1'b0, data_b, perr_b, ferr_b, brk_b, valid_b, ovr_b, 3'(u_b.state_q)};
      default: o = {data_c, perr_c, ferr_c, brk_c, valid_c, ovr_c, 3'(u_c.state_q)};
    endcase
    return o;
  endfunction

  task automatic set_rxd(input int which, input logic v);
    case (which)
      0:       rxd_a = v;
      1:       rxd_b = v;
      default: rxd_c = v;
    endcase
  endtask

  // Bits are sent LSB first, each held for one bit period, changing on the falling clock edge.
  task automatic drive_bits(input int which, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      set_rxd(which, bits[i]);
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic wait_valid(input int which, input int budget, output bit ok);
    obs_t o;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      o = observe(which);
      if (o.valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    obs_t o;
    resetn = 1'b0; rx_en = 1'b1;
    rxd_a = 1'b1; rxd_b = 1'b1; rxd_c = 1'b1;
    ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1;
    repeat (3) @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      o = observe(w);
      n_checks++;
      if ({o.data, o.perr, o.ferr, o.brk, o.valid, o.ovr, o.state} !== '0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: got %h, expected all zero", w, o);
      end
    end
    resetn = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_8n1_basic;
    bit ok; exp_t e; obs_t o; int vcnt;
    sb_q.push_back({8'hA5, 1'b0, 1'b0, 1'b0});
    fork
      drive_bits(0, 16'({1'b1, 8'hA5, 1'b0}), 10);
      begin
        wait_valid(0, 200, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL 8n1_valid_timeout: valid never rose, expected a frame"); end
        e = sb_q.pop_front();
        o = observe(0);
        n_checks++;
        if ({o.data, o.perr, o.ferr, o.brk} !== e) begin
          n_fail++;
          $display("FAIL 8n1_frame: got %h, expected %h", {o.data, o.perr, o.ferr, o.brk}, e);
        end
        vcnt = 1;
        repeat (20) begin
          @(negedge clk);
          if (valid_a === 1'b1) vcnt++;
        end
        n_checks++;
        if (vcnt !== 1) begin n_fail++; $display("FAIL 8n1_valid_width: got %0d cycles, expected 1", vcnt); end
      end
    join
  endtask

  task automatic test_back_to_back;
    bit ok; exp_t e; obs_t o;
    sb_q.push_back({8'h5A, 1'b0, 1'b0, 1'b0});
    sb_q.push_back({8'hC3, 1'b0, 1'b0, 1'b0});
    fork
      begin
        drive_bits(0, 16'({1'b1, 8'h5A, 1'b0}), 10);
        drive_bits(0, 16'({1'b1, 8'hC3, 1'b0}), 10);
      end
      for (int k = 0; k < 2; k++) begin
        wait_valid(0, 200, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL b2b_valid_timeout frame %0d: no valid, expected a frame", k); end
        e = sb_q.pop_front();
        o = observe(0);
        n_checks++;
        if ({o.data, o.perr, o.ferr, o.brk} !== e) begin
          n_fail++;
          $display("FAIL b2b_frame %0d: got %h, expected %h", k, {o.data, o.perr, o.ferr, o.brk}, e);
        end
      end
    join
    repeat (10) @(negedge clk);
  endtask

  task automatic test_7e1_parity;
    bit ok; exp_t e; obs_t o;
    logic [6:0] dv [3] = '{7'h41, 7'h41, 7'h07};
    logic       pv [3] = '{1'b1, 1'b0, 1'b1};
    logic       pe [3] = '{1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 3; k++) begin
      sb_q.push_back({1'b0, dv[k], pe[k], 1'b0, 1'b0});
      fork
        drive_bits(1, 16'({1'b1, pv[k], dv[k], 1'b0}), 10);
        begin
          wait_valid(1, 200, ok);
          n_checks++;
          if (!ok) begin n_fail++; $display("FAIL 7e1_valid_timeout case %0d: no valid, expected a frame", k); end
          e = sb_q.pop_front();
          o = observe(1);
          n_checks++;
          if ({o.data, o.perr, o.ferr, o.brk} !== e) begin
            n_fail++;
            $display("FAIL 7e1_frame case %0d: got %h, expected %h", k, {o.data, o.perr, o.ferr, o.brk}, e);
          end
        end
      join
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic test_8n2_frame_err;
    bit ok; exp_t e; obs_t o; int vcnt;
    sb_q.push_back({8'h3C, 1'b0, 1'b1, 1'b0});
    fork
      drive_bits(2, 16'({1'b0, 1'b1, 8'h3C, 1'b0}), 11);
      begin
        wait_valid(2, 200, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL 8n2_valid_timeout: no valid, expected a frame"); end
        e = sb_q.pop_front();
        o = observe(2);
        n_checks++;
        if ({o.data, o.perr, o.ferr, o.brk} !== e) begin
          n_fail++;
          $display("FAIL 8n2_frame: got %h, expected %h", {o.data, o.perr, o.ferr, o.brk}, e);
        end
      end
    join
    repeat (3) @(negedge clk);
    vcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid_c === 1'b1) vcnt++;
    end
    o = observe(2);
    n_checks++;
    if (vcnt !== 0 || o.state !== S_WAIT_HIGH) begin
      n_fail++;
      $display("FAIL 8n2_hold_low: got valid_cycles=%0d state=%0d, expected 0 and %0d", vcnt, o.state, S_WAIT_HIGH);
    end
    rxd_c = 1'b1;
    repeat (5) @(negedge clk);
    o = observe(2);
    n_checks++;
    if (o.state !== S_IDLE) begin n_fail++; $display("FAIL 8n2_release: got state=%0d, expected %0d", o.state, S_IDLE); end
  endtask

  task automatic test_break;
    bit ok; exp_t e; obs_t o; int vcnt;
    sb_q.push_back({8'h00, 1'b0, 1'b1, 1'b1});
    fork
      begin
        rxd_a = 1'b0;
        repeat (12 * CPB) @(negedge clk);
      end
      begin
        wait_valid(0, 150, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL break_valid_timeout: no valid, expected a frame"); end
        e = sb_q.pop_front();
        o = observe(0);
        n_checks++;
        if ({o.data, o.perr, o.ferr, o.brk} !== e) begin
          n_fail++;
          $display("FAIL break_frame: got %h, expected %h", {o.data, o.perr, o.ferr, o.brk}, e);
        end
      end
    join
    o = observe(0);
    n_checks++;
    if (o.state !== S_WAIT_HIGH) begin n_fail++; $display("FAIL break_wait_high: got state=%0d, expected %0d", o.state, S_WAIT_HIGH); end
    rxd_a = 1'b1;
    vcnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (valid_a === 1'b1) vcnt++;
    end
    o = observe(0);
    n_checks++;
    if (o.state !== S_IDLE || vcnt !== 0) begin
      n_fail++;
      $display("FAIL break_release: got state=%0d valid_cycles=%0d, expected %0d and 0", o.state, vcnt, S_IDLE);
    end
  endtask

  task automatic test_glitch;
    obs_t o; int vcnt;
    rxd_a = 1'b0;
    repeat (3) @(negedge clk);
    rxd_a = 1'b1;
    vcnt = 0;
    repeat (130) begin
      @(negedge clk);
      if (valid_a === 1'b1) vcnt++;
    end
    o = observe(0);
    n_checks++;
    if (vcnt !== 0 || o.state !== S_IDLE) begin
      n_fail++;
      $display("FAIL glitch_reject: got valid_cycles=%0d state=%0d, expected 0 and %0d", vcnt, o.state, S_IDLE);
    end
  endtask

  task automatic test_overrun;
    bit ok; exp_t e; obs_t o;
    ready_a = 1'b0;
    sb_q.push_back({8'h11, 1'b0, 1'b0, 1'b0});
    fork
      drive_bits(0, 16'({1'b1, 8'h11, 1'b0}), 10);
      begin
        wait_valid(0, 200, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL ovr_first_timeout: no valid, expected a frame"); end
      end
    join
    drive_bits(0, 16'({1'b1, 8'h22, 1'b0}), 10);
    for (int i = 0; i < 20; i++) begin
      if (ovr_a === 1'b1) break;
      @(negedge clk);
    end
    e = sb_q.pop_front();
    o = observe(0);
    n_checks++;
    if ({o.data, o.perr, o.ferr, o.brk, o.valid, o.ovr} !== {e, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL ovr_hold: got %h, expected %h", {o.data, o.perr, o.ferr, o.brk, o.valid, o.ovr}, {e, 1'b1, 1'b1});
    end
    ready_a = 1'b1;
    @(negedge clk);
    o = observe(0);
    n_checks++;
    if (o.valid !== 1'b0 || o.ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_clear: got valid=%b overrun=%b, expected 0 0", o.valid, o.ovr);
    end
  endtask

  task automatic test_reset_midframe;
    obs_t o; int vcnt;
    vcnt = 0;
    fork
      drive_bits(0, 16'({1'b1, 8'hFF, 1'b0}), 10);
      begin
        repeat (35) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        o = observe(0);
        n_checks++;
        if ({o.data, o.perr, o.ferr, o.brk, o.valid, o.ovr, o.state} !== '0) begin
          n_fail++;
          $display("FAIL midframe_reset_state: got %h, expected all zero", o);
        end
        repeat (4) @(negedge clk);
        resetn = 1'b1;
        repeat (60) begin
          @(negedge clk);
          if (valid_a === 1'b1) vcnt++;
        end
      end
    join
    repeat (80) begin
      @(negedge clk);
      if (valid_a === 1'b1) vcnt++;
    end
    o = observe(0);
    n_checks++;
    if (vcnt !== 0 || o.state !== S_IDLE) begin
      n_fail++;
      $display("FAIL midframe_discard: got valid_cycles=%0d state=%0d, expected 0 and %0d", vcnt, o.state, S_IDLE);
    end
  endtask

  task automatic test_rx_en_abort;
    obs_t o; int vcnt;
    vcnt = 0;
    fork
      drive_bits(0, 16'({1'b1, 8'hFF, 1'b0}), 10);
      begin
        repeat (30) @(negedge clk);
        rx_en = 1'b0;
        @(negedge clk);
        o = observe(0);
        n_checks++;
        if (o.state !== S_IDLE) begin n_fail++; $display("FAIL rx_en_idle: got state=%0d, expected %0d", o.state, S_IDLE); end
      end
    join
    rx_en = 1'b1;
    repeat (130) begin
      @(negedge clk);
      if (valid_a === 1'b1) vcnt++;
    end
    n_checks++;
    if (vcnt !== 0) begin n_fail++; $display("FAIL rx_en_abort: got valid_cycles=%0d, expected 0", vcnt); end
  endtask

  initial begin
    test_reset();
    test_8n1_basic();
    test_back_to_back();
    test_7e1_parity();
    test_8n2_frame_err();
    test_break();
    test_glitch();
    test_overrun();
    test_reset_midframe();
    test_rx_en_abort();
    n_checks++;
    if (sb_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left, expected 0", sb_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
